// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: two-port round-robin arbiter in front of one synchronous single-port memory.
// Port 0 is instruction fetch and port 1 is data. The arbiter grants at most one access per
// cycle. Read data from the memory returns one cycle later to the port that issued the read.
// Each port has a saturating wait-cycle counter for performance debug.
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   pN_req/addr/wdata/wstrb/write   requester N access; held stable until pN_gnt
//   pN_gnt                     request accepted this cycle (combinational)
//   pN_rvalid/pN_rdata         read response for port N (rdata is 0 when rvalid is low)
//   mem_req/addr/wdata/wstrb/write  granted access to the memory (all 0 with no grant)
//   mem_rdata                  memory read data, valid 1 cycle after a read mem_req
//   cnt_clr                    synchronous clear of both wait counters
//   pN_wait_cnt                cycles port N spent requesting without a grant
module mem_rr_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    p0_req,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [DATA_WIDTH-1:0]   p0_wdata,
  input  logic [DATA_WIDTH/8-1:0] p0_wstrb,
  input  logic                    p0_write,
  input  logic                    p1_req,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  input  logic [DATA_WIDTH/8-1:0] p1_wstrb,
  input  logic                    p1_write,
  output logic                    p0_gnt,
  output logic                    p1_gnt,
  output logic                    p0_rvalid,
  output logic                    p1_rvalid,
  output logic [DATA_WIDTH-1:0]   p0_rdata,
  output logic [DATA_WIDTH-1:0]   p1_rdata,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic                    mem_write,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    cnt_clr,
  output logic [CNT_WIDTH-1:0]    p0_wait_cnt,
  output logic [CNT_WIDTH-1:0]    p1_wait_cnt
);

  logic                 r_last_gnt;
  logic                 r_resp_valid;
  logic                 r_resp_port;
  logic [CNT_WIDTH-1:0] r_p0_cnt;
  logic [CNT_WIDTH-1:0] r_p1_cnt;

  logic w_p0_gnt;
  logic w_p1_gnt;

  // On a conflict the port that did not win last time goes first (last_gnt=1 favours port 0).
  assign w_p0_gnt = p0_req & (~p1_req | r_last_gnt);
  assign w_p1_gnt = p1_req & (~p0_req | ~r_last_gnt);

  assign p0_gnt  = w_p0_gnt;
  assign p1_gnt  = w_p1_gnt;
  assign mem_req = w_p0_gnt | w_p1_gnt;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    mem_write = 1'b0;
    if (w_p0_gnt) begin
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
      mem_wstrb = p0_wstrb;
      mem_write = p0_write;
    end else if (w_p1_gnt) begin
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
      mem_wstrb = p1_wstrb;
      mem_write = p1_write;
    end
  end

  // Response tracking: remembers which port owns the read data arriving next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt   <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_port  <= 1'b0;
    end else begin
      if (mem_req) begin
        r_last_gnt <= w_p1_gnt;
      end
      r_resp_valid <= mem_req & ~mem_write;
      r_resp_port  <= w_p1_gnt;
    end
  end

  assign p0_rvalid = r_resp_valid & ~r_resp_port;
  assign p1_rvalid = r_resp_valid & r_resp_port;
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

  // Saturating wait counters; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p0_cnt <= '0;
      r_p1_cnt <= '0;
    end else if (cnt_clr) begin
      r_p0_cnt <= '0;
      r_p1_cnt <= '0;
    end else begin
      if (p0_req && !w_p0_gnt && !(&r_p0_cnt)) begin
        r_p0_cnt <= r_p0_cnt + CNT_WIDTH'(1);
      end
      if (p1_req && !w_p1_gnt && !(&r_p1_cnt)) begin
        r_p1_cnt <= r_p1_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign p0_wait_cnt = r_p0_cnt;
  assign p1_wait_cnt = r_p1_cnt;

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Two-requester round-robin arbiter that shares one synchronous single-port memory between the core's instruction-fetch port (port 0) and data port (port 1). It sits between the core and a unified memory with a 1-cycle read latency, replacing the separate zero-latency instruction and data memories. It grants at most one access per cycle and routes read data back to the port that issued the read. It also keeps per-port saturating wait-cycle counters for performance debug.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- CNT_WIDTH, 16, width of each wait counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- p0_req / p1_req  in  1  access request, held until granted
- p0_addr / p1_addr  in  ADDR_WIDTH  byte address
- p0_wdata / p1_wdata  in  DATA_WIDTH  write data
- p0_wstrb / p1_wstrb  in  DATA_WIDTH/8  byte write strobes
- p0_write / p1_write  in  1  1 = write, 0 = read
- p0_gnt / p1_gnt  out  1  request accepted this cycle (combinational)
- p0_rvalid / p1_rvalid  out  1  read data valid for this port
- p0_rdata / p1_rdata  out  DATA_WIDTH  read data, 0 when rvalid low
- mem_req  out  1  memory access this cycle
- mem_addr  out  ADDR_WIDTH  granted address
- mem_wdata  out  DATA_WIDTH  granted write data
- mem_wstrb  out  DATA_WIDTH/8  granted strobes
- mem_write  out  1  granted write enable
- mem_rdata  in  DATA_WIDTH  memory read data, valid 1 cycle after a read mem_req
- cnt_clr  in  1  synchronous clear of both wait counters
- p0_wait_cnt / p1_wait_cnt  out  CNT_WIDTH  cycles spent requesting without grant

## Operation
- State: last_gnt (1 bit), resp_valid (1 bit), resp_port (1 bit), two wait counters.
- Arbitration, same cycle:
  - only one req high: grant that port.
  - both high: grant the port != last_gnt.
  - neither high: no grant.
- last_gnt updates to the granted port on any grant; unchanged otherwise. Reset value 1, so port 0 wins the first conflict.
- mem_req = p0_gnt | p1_gnt. mem_addr/wdata/wstrb/write are muxed from the granted port. When there is no grant, all are 0.
- On a granted read, the next cycle has resp_valid=1 and resp_port=granted port. A granted write or no grant gives resp_valid=0 next cycle.
- pN_rvalid = resp_valid & (resp_port==N). pN_rdata = mem_rdata when pN_rvalid, else 0.
- Requesters must hold req/addr/wdata/wstrb/write stable until gnt. Dropping req before gnt is legal and simply withdraws the request.
- Wait counter N:
  - +1 on each cycle with pN_req=1 and pN_gnt=0.
  - saturates at 2^CNT_WIDTH-1.
  - cnt_clr=1 sets it to 0 and takes precedence over increment in the same cycle.
- Reset (async, any time): last_gnt=1, resp_valid=0, resp_port=0, counters=0. A read in flight at reset is dropped with no rvalid. Combinational outputs follow the inputs immediately after reset.

## Timing
- req to gnt: 0 cycles (combinational). Gnt and mem_req occur in the same cycle.
- Read latency: rvalid/rdata arrive 1 cycle after gnt.
- Throughput: 1 access per cycle. Back-to-back reads from alternating ports each return in order, one per cycle.
- Fairness: with both ports requesting continuously, grants alternate strictly. Worst-case wait is 1 cycle per access.
- Reset values of outputs: all gnt, rvalid, rdata, mem_* = 0 with reqs low. wait counters = 0.
- No combinational path from mem_rdata to any gnt or mem_* output.

## Test plan
- Reset, then p0 reads addr 0x10 alone; memory returns 0x13 -> p0_gnt=1 same cycle, p0_rvalid=1 with p0_rdata=0x13 next cycle, p1_rvalid=0, p1_rdata=0.
- Both ports request reads on the first cycle after reset, held for 4 cycles -> grants p0,p1,p0,p1; rvalid follows each grant by 1 cycle to the matching port; p0_wait_cnt=0, p1_wait_cnt=1 after the first conflict.
- p1 writes 0xdeadbeef to 0x40 with wstrb=0xF while p0 idles -> mem_write=1, mem_addr=0x40, mem_wdata=0xdeadbeef; no rvalid next cycle.
- p1 held requesting while p0 wins: with CNT_WIDTH=4, force 20 stalled cycles via a repeated conflict -> counter saturates at 15. Assert cnt_clr together with a stall -> counter reads 0 next cycle.
- Assert rst in the cycle after a granted read -> no rvalid, last_gnt=1, so the next conflict grants p0.
- p0 raises req and drops it before grant during a conflict -> no access to p0's address, and last_gnt is unaffected by the withdrawn request.
